// File: rtl/core_pipe_decode_pkg.sv
// core_pipe_decode_pkg: opcode classes, immediate formats and trap codes for the decode stage
package core_pipe_decode_pkg;
  typedef enum logic [3:0] {
    OC_LOAD, OC_MISC_MEM, OC_OP_IMM, OC_AUIPC, OC_OP_IMM_32, OC_STORE, OC_OP, OC_LUI,
    OC_OP_32, OC_BRANCH, OC_JALR, OC_JAL, OC_SYSTEM, OC_C16, OC_ILLEGAL
  } opclass_e;
  typedef enum logic [2:0] {FMT_Z, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_e;
  localparam logic [1:0] TRAP_NONE    = 2'd0;
  localparam logic [1:0] TRAP_FETCH   = 2'd1;
  localparam logic [1:0] TRAP_ILLEGAL = 2'd2;
  localparam logic [4:0] OPC_LOAD      = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM  = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
  localparam logic [4:0] OPC_AUIPC     = 5'b00101;
  localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
  localparam logic [4:0] OPC_STORE     = 5'b01000;
  localparam logic [4:0] OPC_OP        = 5'b01100;
  localparam logic [4:0] OPC_LUI       = 5'b01101;
  localparam logic [4:0] OPC_OP_32     = 5'b01110;
  localparam logic [4:0] OPC_BRANCH    = 5'b11000;
  localparam logic [4:0] OPC_JALR      = 5'b11001;
  localparam logic [4:0] OPC_JAL       = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM    = 5'b11100;

  function automatic opclass_e opclass_of(input logic [4:0] op);
    case (op)
      OPC_LOAD:      return OC_LOAD;
      OPC_MISC_MEM:  return OC_MISC_MEM;
      OPC_OP_IMM:    return OC_OP_IMM;
      OPC_AUIPC:     return OC_AUIPC;
      OPC_OP_IMM_32: return OC_OP_IMM_32;
      OPC_STORE:     return OC_STORE;
      OPC_OP:        return OC_OP;
      OPC_LUI:       return OC_LUI;
      OPC_OP_32:     return OC_OP_32;
      OPC_BRANCH:    return OC_BRANCH;
      OPC_JALR:      return OC_JALR;
      OPC_JAL:       return OC_JAL;
      OPC_SYSTEM:    return OC_SYSTEM;
      default:       return OC_ILLEGAL;
    endcase
  endfunction

  function automatic imm_fmt_e fmt_of(input opclass_e c);
    case (c)
      OC_LOAD, OC_MISC_MEM, OC_OP_IMM, OC_OP_IMM_32, OC_JALR, OC_SYSTEM: return FMT_I;
      OC_STORE:         return FMT_S;
      OC_BRANCH:        return FMT_B;
      OC_LUI, OC_AUIPC: return FMT_U;
      OC_JAL:           return FMT_J;
      default:          return FMT_Z;
    endcase
  endfunction
endpackage

// File: rtl/core_pipe_decode_if.sv
// core_pipe_decode_if: fetch-side (s1) and execute-side (s2) signals of the decode stage
interface core_pipe_decode_if #(parameter int XLEN = 64, parameter int FD_ERR_W = 2);
  logic                s1_i16bit;
  logic                s1_i32bit;
  logic [31:0]         s1_instr;
  logic [XLEN-1:0]     s1_pc;
  logic [XLEN-1:0]     s1_npc;
  logic [FD_ERR_W-1:0] s1_ferr;
  logic                s1_eat_2;
  logic                s1_eat_4;
  logic                s2_valid;
  logic                s2_ready;
  logic [XLEN-1:0]     s2_pc;
  logic [XLEN-1:0]     s2_npc;
  logic [31:0]         s2_instr;
  logic [3:0]          s2_opclass;
  logic [4:0]          s2_rd;
  logic [4:0]          s2_rs1;
  logic [4:0]          s2_rs2;
  logic [XLEN-1:0]     s2_imm;
  logic                s2_trap;
  logic [1:0]          s2_trap_cause;
  modport master (
    output s1_i16bit, s1_i32bit, s1_instr, s1_pc, s1_npc, s1_ferr, s2_ready,
    input  s1_eat_2, s1_eat_4, s2_valid, s2_pc, s2_npc, s2_instr, s2_opclass,
    input  s2_rd, s2_rs1, s2_rs2, s2_imm, s2_trap, s2_trap_cause
  );
  modport slave (
    input  s1_i16bit, s1_i32bit, s1_instr, s1_pc, s1_npc, s1_ferr, s2_ready,
    output s1_eat_2, s1_eat_4, s2_valid, s2_pc, s2_npc, s2_instr, s2_opclass,
    output s2_rd, s2_rs1, s2_rs2, s2_imm, s2_trap, s2_trap_cause
  );
endinterface

// File: rtl/core_pipe_decode_imm.sv
// core_pipe_decode_imm: assembles the sign-extended immediate for a given format
module core_pipe_decode_imm
  import core_pipe_decode_pkg::*;
#(parameter int XLEN = 64) (
  input  logic [31:7]     instr,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);
  logic s;
  assign s = instr[31];
  always_comb
    imm = (fmt == FMT_I) ? {{(XLEN-12){s}}, instr[31:20]} :
          (fmt == FMT_S) ? {{(XLEN-12){s}}, instr[31:25], instr[11:7]} :
          (fmt == FMT_B) ? {{(XLEN-13){s}}, s, instr[7], instr[30:25], instr[11:8], 1'b0} :
          (fmt == FMT_U) ? {{(XLEN-32){s}}, instr[31:12], 12'h000} :
          (fmt == FMT_J) ? {{(XLEN-21){s}}, s, instr[19:12], instr[20], instr[30:21], 1'b0} :
                           '0;
endmodule

// File: rtl/core_pipe_decode.sv
// core_pipe_decode: classifies fetched instructions and registers them into the s2 pipeline slot
module core_pipe_decode
  import core_pipe_decode_pkg::*;
#(parameter int XLEN = 64) (
  input logic                g_clk,
  input logic                g_reset,
  input logic                flush,
  core_pipe_decode_if.slave  dec
);
  logic            accept;
  logic            is32;
  opclass_e        cls;
  imm_fmt_e        fmt;
  logic [1:0]      cause;
  logic [XLEN-1:0] imm;
  always_comb begin
    is32   = dec.s1_i32bit;
    accept = (dec.s1_i16bit | dec.s1_i32bit) & (!dec.s2_valid | dec.s2_ready) & !flush & !g_reset;
    cls    = !is32 ? OC_C16 : (dec.s1_instr[1:0] == 2'b11) ? opclass_of(dec.s1_instr[6:2]) : OC_ILLEGAL;
    fmt    = fmt_of(cls);
    cause  = is32 ? ((|dec.s1_ferr) ? TRAP_FETCH :
                     (cls == OC_ILLEGAL || &dec.s1_instr) ? TRAP_ILLEGAL : TRAP_NONE) :
                    (dec.s1_ferr[0] ? TRAP_FETCH :
                     (dec.s1_instr[15:0] == 16'h0000) ? TRAP_ILLEGAL : TRAP_NONE);
  end
  assign dec.s1_eat_2 = accept & dec.s1_i16bit;
  assign dec.s1_eat_4 = accept & dec.s1_i32bit;
  core_pipe_decode_imm #(.XLEN(XLEN)) u_imm (
    .instr (dec.s1_instr[31:7]),
    .fmt   (fmt),
    .imm   (imm)
  );
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      dec.s2_valid      <= 1'b0;
      dec.s2_pc         <= '0;
      dec.s2_npc        <= '0;
      dec.s2_instr      <= '0;
      dec.s2_opclass    <= '0;
      dec.s2_rd         <= '0;
      dec.s2_rs1        <= '0;
      dec.s2_rs2        <= '0;
      dec.s2_imm        <= '0;
      dec.s2_trap       <= 1'b0;
      dec.s2_trap_cause <= '0;
    end else begin
      dec.s2_valid <= flush ? 1'b0 : accept ? 1'b1 : dec.s2_ready ? 1'b0 : dec.s2_valid;
      if (accept) begin
        dec.s2_pc         <= dec.s1_pc;
        dec.s2_npc        <= dec.s1_npc;
        dec.s2_instr      <= is32 ? dec.s1_instr : {16'h0000, dec.s1_instr[15:0]};
        dec.s2_opclass    <= cls;
        dec.s2_rd         <= is32 ? dec.s1_instr[11:7] : 5'd0;
        dec.s2_rs1        <= is32 ? dec.s1_instr[19:15] : 5'd0;
        dec.s2_rs2        <= is32 ? dec.s1_instr[24:20] : 5'd0;
        dec.s2_imm        <= imm;
        dec.s2_trap       <= cause != TRAP_NONE;
        dec.s2_trap_cause <= cause;
      end
    end
  end
endmodule

// File: tb/tb_core_pipe_decode.sv
// tb_core_pipe_decode: randomized scoreboard bench for the decode stage
module tb_core_pipe_decode;
  import core_pipe_decode_pkg::*;
  localparam int XLEN = 64;
  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc, npc, imm;
    logic [3:0]  cls;
    logic [4:0]  rd, rs1, rs2;
    logic [1:0]  cause;
  } exp_t;
  logic g_clk = 1'b0, g_reset = 1'b1, flush = 1'b0;
  always #5 g_clk = ~g_clk;
  core_pipe_decode_if #(.XLEN(XLEN), .FD_ERR_W(2)) bus ();
  core_pipe_decode #(.XLEN(XLEN)) dut (.g_clk(g_clk), .g_reset(g_reset), .flush(flush), .dec(bus));
  exp_t q[$];
  bit   exp_occ = 0, occ_nxt = 0, clr = 0, mon_en = 0;
  int   compared = 0, mismatched = 0;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  function automatic exp_t ref_decode(input bit i32, input logic [31:0] instr, input logic [1:0] ferr,
                                      input logic [63:0] pc, input logic [63:0] npc);
    exp_t e;
    byte f;
    longint b, v;
    e.pc = pc; e.npc = npc;
    if (!i32) begin
      e.instr = {16'h0000, instr[15:0]};
      e.cls = OC_C16; e.rd = 0; e.rs1 = 0; e.rs2 = 0; e.imm = 0;
      e.cause = ferr[0] ? 2'd1 : (instr[15:0] == 16'h0000) ? 2'd2 : 2'd0;
      return e;
    end
    e.instr = instr; e.rd = instr[11:7]; e.rs1 = instr[19:15]; e.rs2 = instr[24:20];
    f = "Z";
    case (instr[6:2])
      5'b00000: begin e.cls = OC_LOAD;      f = "I"; end
      5'b00011: begin e.cls = OC_MISC_MEM;  f = "I"; end
      5'b00100: begin e.cls = OC_OP_IMM;    f = "I"; end
      5'b00101: begin e.cls = OC_AUIPC;     f = "U"; end
      5'b00110: begin e.cls = OC_OP_IMM_32; f = "I"; end
      5'b01000: begin e.cls = OC_STORE;     f = "S"; end
      5'b01100: e.cls = OC_OP;
      5'b01101: begin e.cls = OC_LUI;       f = "U"; end
      5'b01110: e.cls = OC_OP_32;
      5'b11000: begin e.cls = OC_BRANCH;    f = "B"; end
      5'b11001: begin e.cls = OC_JALR;      f = "I"; end
      5'b11011: begin e.cls = OC_JAL;       f = "J"; end
      5'b11100: begin e.cls = OC_SYSTEM;    f = "I"; end
      default:  e.cls = OC_ILLEGAL;
    endcase
    b = longint'(instr[31]);
    case (f)
      "I": v = -b * 2048 + longint'(instr[30:20]);
      "S": v = -b * 2048 + longint'(instr[30:25]) * 32 + longint'(instr[11:7]);
      "B": v = -b * 4096 + longint'(instr[7]) * 2048 + longint'(instr[30:25]) * 32 + longint'(instr[11:8]) * 2;
      "U": v = -b * 64'sh8000_0000 + longint'(instr[30:12]) * 4096;
      "J": v = -b * 64'sh10_0000 + longint'(instr[19:12]) * 4096 + longint'(instr[20]) * 2048 + longint'(instr[30:21]) * 2;
      default: v = 0;
    endcase
    e.imm = v;
    e.cause = (|ferr) ? 2'd1 : (e.cls == OC_ILLEGAL || instr == 32'hFFFF_FFFF) ? 2'd2 : 2'd0;
    return e;
  endfunction

  task automatic issue(input bit i16, input bit i32, input logic [31:0] instr, input logic [1:0] ferr,
                       input logic [63:0] pc, input bit rdy, input bit fl, input bit rst);
    bit acc;
    @(posedge g_clk);
    exp_occ = occ_nxt;
    if (clr) begin q.delete(); clr = 0; end
    #1;
    g_reset = rst; flush = fl;
    bus.s1_i16bit = i16; bus.s1_i32bit = i32; bus.s1_instr = instr; bus.s1_ferr = ferr;
    bus.s1_pc = pc; bus.s1_npc = pc + (i32 ? 64'd4 : 64'd2); bus.s2_ready = rdy;
    #1;
    acc = (i16 || i32) && (!exp_occ || rdy) && !fl && !rst;
    chk("eat_2", bus.s1_eat_2, acc && i16);
    chk("eat_4", bus.s1_eat_4, acc && i32);
    occ_nxt = (rst || fl) ? 0 : acc ? 1 : rdy ? 0 : exp_occ;
    if (rst) clr = 1;
    if (acc) q.push_back(ref_decode(i32, instr, ferr, pc, pc + (i32 ? 64'd4 : 64'd2)));
  endtask

  task automatic dir(input bit i16, input logic [31:0] instr, input logic [1:0] ferr);
    issue(i16, !i16, instr, ferr, 64'h2000, 1, 0, 0);
    issue(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge g_clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge g_clk);
      if (mon_en) begin
        chk("s2_valid", bus.s2_valid, exp_occ);
        if (exp_occ && bus.s2_valid) begin
          if (q.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL scoreboard: s2 valid but no expected entry");
          end else begin
            e = q[0];
            chk("s2_instr", bus.s2_instr, e.instr);
            chk("s2_pc", bus.s2_pc, e.pc);
            chk("s2_npc", bus.s2_npc, e.npc);
            chk("s2_opclass", bus.s2_opclass, e.cls);
            chk("s2_rd", bus.s2_rd, e.rd);
            chk("s2_rs1", bus.s2_rs1, e.rs1);
            chk("s2_rs2", bus.s2_rs2, e.rs2);
            chk("s2_imm", bus.s2_imm, e.imm);
            chk("s2_trap", bus.s2_trap, e.cause != 0);
            chk("s2_trap_cause", bus.s2_trap_cause, e.cause);
            if (bus.s2_ready || flush || g_reset) void'(q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int ops[13] = '{0, 3, 4, 5, 6, 8, 12, 13, 14, 24, 25, 27, 28};
    logic [31:0] r, ins;
    logic [63:0] pc;
    int sel;
    issue(0, 1, 32'hFFF00093, 0, 64'h1000, 1, 0, 1);
    issue(0, 1, 32'hFFF00093, 0, 64'h1000, 1, 0, 1);
    @(negedge g_clk);
    chk("rst_valid", bus.s2_valid, 0);
    chk("rst_pc", bus.s2_pc, 0);
    chk("rst_npc", bus.s2_npc, 0);
    chk("rst_instr", bus.s2_instr, 0);
    chk("rst_fields", {bus.s2_opclass, bus.s2_rd, bus.s2_rs1, bus.s2_rs2}, 0);
    chk("rst_imm", bus.s2_imm, 0);
    chk("rst_trap", {bus.s2_trap, bus.s2_trap_cause}, 0);
    mon_en = 1;
    issue(0, 1, 32'hFFF00093, 0, 64'h1000_0000, 1, 0, 0);
    issue(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge g_clk);
    chk("addi_opclass", bus.s2_opclass, OC_OP_IMM);
    chk("addi_rd", bus.s2_rd, 1);
    chk("addi_rs1", bus.s2_rs1, 0);
    chk("addi_imm", bus.s2_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_npc", bus.s2_npc, 64'h1000_0004);
    chk("addi_trap", bus.s2_trap, 0);
    issue(0, 1, 32'h008000EF, 0, 64'h3000, 0, 0, 0);
    chk("bp_held_opclass", bus.s2_opclass, OC_OP_IMM);
    issue(0, 1, 32'h008000EF, 0, 64'h3000, 1, 0, 0);
    issue(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge g_clk);
    chk("jal_opclass", bus.s2_opclass, OC_JAL);
    chk("jal_rd", bus.s2_rd, 1);
    chk("jal_imm", bus.s2_imm, 8);
    issue(0, 1, 32'hFFF00093, 0, 64'h4000, 0, 1, 0);
    issue(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge g_clk);
    chk("flush_valid", bus.s2_valid, 0);
    dir(1, 32'h0000_0001, 2'b10);
    chk("c16_ferr_hi_trap", bus.s2_trap, 0);
    chk("c16_opclass", bus.s2_opclass, OC_C16);
    dir(0, 32'hFFF00093, 2'b10);
    chk("i32_ferr_trap", bus.s2_trap, 1);
    chk("i32_ferr_cause", bus.s2_trap_cause, TRAP_FETCH);
    dir(1, 32'hABCD_0000, 2'b00);
    chk("c16_zero_cause", bus.s2_trap_cause, TRAP_ILLEGAL);
    chk("c16_upper_zero", bus.s2_instr, 0);
    dir(0, 32'h0000_007F, 2'b00);
    chk("long_enc_cause", bus.s2_trap_cause, TRAP_ILLEGAL);
    dir(0, 32'h0000_007F, 2'b01);
    chk("fetch_prio_cause", bus.s2_trap_cause, TRAP_FETCH);
    dir(0, 32'hFFFF_FFFF, 2'b00);
    chk("all_ones_cause", bus.s2_trap_cause, TRAP_ILLEGAL);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom();
      sel = $urandom_range(0, 99);
      ins = ($urandom_range(0, 9) < 8) ? {r[31:7], 5'(ops[$urandom_range(0, 12)]), 2'b11} : {r[31:2], 2'b11};
      if ($urandom_range(0, 49) == 0) ins = 32'hFFFF_FFFF;
      if (sel < 30 && $urandom_range(0, 9) == 0) ins[15:0] = 16'h0000;
      pc = {32'($urandom()), 32'($urandom())} & ~64'h1;
      issue(sel < 30, sel >= 30 && sel < 85, ins, ($urandom_range(0, 4) == 0) ? 2'($urandom()) : 2'b00,
            pc, $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0);
    end
    for (int i = 0; i < 3; i++) issue(0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge g_clk);
    chk("drain_queue", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/core_pipe_decode.md
Name: core_pipe_decode

Overview:
- Pipeline stage 2, directly downstream of the fetch stage.
- Consumes the instruction presented on the s1_* interface and returns s1_eat_2/s1_eat_4 to drain the fetch buffer.
- Classifies 32-bit RV64IM/Zicsr encodings and extracts register indices and a sign-extended immediate.
- Tags fetch faults and illegal encodings, then registers the result into a valid/ready s2 pipeline register for execute. 16-bit instructions pass raw, class C16, for a later expander.

Parameters:
- XLEN, 64, data/PC width.
- FD_ERR_W, 2, per-halfword fetch error bits.

Ports:
- g_clk  in  1  global clock
- g_reset  in  1  synchronous active-high reset
- s1_i16bit  in  1  16-bit instruction present
- s1_i32bit  in  1  32-bit instruction present
- s1_instr  in  32  instruction bits; a 16-bit instruction uses [15:0]
- s1_pc  in  XLEN  instruction PC
- s1_npc  in  XLEN  next PC
- s1_ferr  in  2  fetch error; bit0 = low halfword, bit1 = high halfword
- s1_eat_2  out  1  consume 2 bytes
- s1_eat_4  out  1  consume 4 bytes
- flush  in  1  control-flow change this cycle
- s2_valid  out  1  s2 register holds an instruction
- s2_ready  in  1  execute accepts s2
- s2_pc  out  XLEN  PC of s2 instruction
- s2_npc  out  XLEN  next PC of s2 instruction
- s2_instr  out  32  raw instruction
- s2_opclass  out  4  major opcode class
- s2_rd  out  5  destination register index
- s2_rs1  out  5  source register 1 index
- s2_rs2  out  5  source register 2 index
- s2_imm  out  XLEN  sign-extended immediate
- s2_trap  out  1  instruction raises a trap
- s2_trap_cause  out  2  trap cause code

Behaviour:
- Reset (g_reset=1 at posedge): s2_valid=0. All s2 data outputs, s2_trap and s2_trap_cause = 0. s1_eat_* are combinational and must be 0 while reset is asserted.
- Acceptance: accept = (s1_i16bit|s1_i32bit) & (!s2_valid | s2_ready) & !flush & !g_reset.
- s1_eat_2 = accept & s1_i16bit; s1_eat_4 = accept & s1_i32bit. Never both asserted. Outputs are combinational, so there are zero cycles from presentation to eat.
- s2 register, next s2_valid:
  - flush: 0. Flush wins over accept and over s2_ready.
  - else accept: 1.
  - else s2_ready: 0.
  - else: hold.
- Data registers load only on accept and otherwise hold (stable under backpressure). Latency is 1 cycle from s1 presentation to s2_valid.
- Decoding of 32-bit instructions (instr[1:0]=11) uses opcode bits [6:2]:
  - LOAD 00000, MISC_MEM 00011, OP_IMM 00100, AUIPC 00101, OP_IMM_32 00110, STORE 01000, OP 01100, LUI 01101, OP_32 01110, BRANCH 11000, JALR 11001, JAL 11011, SYSTEM 11100.
  - Any other value → ILLEGAL. This includes [4:2]=111, i.e. 48-bit and longer encodings.
- Register fields: rd=[11:7], rs1=[19:15], rs2=[24:20], always extracted raw.
- Immediate format by class:
  - I: LOAD, OP_IMM, OP_IMM_32, JALR, SYSTEM, MISC_MEM.
  - S: STORE.
  - B: BRANCH.
  - U: LUI, AUIPC. U-type is [31:12]<<12, then sign-extended from bit 31.
  - J: JAL.
  - OP, OP_32: imm=0.
  - All formats are sign-extended to XLEN.
- 16-bit instructions: opclass=C16; rd, rs1, rs2 and imm all 0; s2_instr[31:16]=0.
- Trap causes (2-bit): NONE=0, FETCH=1, ILLEGAL=2. FETCH has priority over ILLEGAL.
  - FETCH for 16-bit if s1_ferr[0].
  - FETCH for 32-bit if |s1_ferr.
  - ILLEGAL for 16-bit if instr[15:0]==0.
  - ILLEGAL for 32-bit if class ILLEGAL or instr==32'hFFFF_FFFF.
- s2_trap = (cause != NONE).
- Trapping instructions still occupy s2 and are consumed normally.
- Reset asserted mid-transfer: s2 is cleared at the same edge and no eat is issued that cycle.

Decomposition:
- Package core_pipe_decode_pkg holds:
  - opclass enum (4-bit: 13 major classes, C16, ILLEGAL).
  - trap cause constants.
  - major opcode [6:2] constants.
  - immediate-format enum.
- Sub-module core_pipe_decode_imm (combinational): instr plus format in, XLEN immediate out.

Test Plan:
- Reset: hold g_reset=1 for 2 cycles with s1_i32bit=1 → s1_eat_4=0, s2_valid=0, all s2_* outputs 0.
- ADDI x1,x0,-1:
  - Stimulus: 32'hFFF00093, pc=0x10000000, npc=0x10000004, s2_ready=1.
  - Same cycle: s1_eat_4=1.
  - Next cycle: s2_valid=1, opclass=OP_IMM, rd=1, rs1=0, imm=0xFFFFFFFFFFFFFFFF, s2_npc=0x10000004, s2_trap=0.
- Backpressure: s2_valid=1, s2_ready=0, JAL x1,+8 (32'h008000EF) presented → eat=0 and s2 unchanged. Raise s2_ready → eat_4=1; next cycle opclass=JAL, rd=1, imm=8.
- Flush: instruction presented with s2_valid=1, s2_ready=0, flush=1 → eat=0; next cycle s2_valid=0.
- Fetch errors:
  - 16-bit c.nop (16'h0001) with ferr=2'b10 → s2_trap=0, opclass=C16.
  - 32-bit instruction with ferr=2'b10 → s2_trap=1, cause=FETCH.
- Illegal encodings:
  - 16'h0000 → cause ILLEGAL.
  - 32'h0000007F → cause ILLEGAL.
  - 32'h0000007F with ferr=2'b01 → cause FETCH (priority).
